// File: rtl/sum_serializer_4lane.sv
// Serializes a 32-bit sum over four 1-bit lanes (one byte per lane, LSB first)
// with a carry held static, a mid-slot strobe, and a finish/ack handshake.
module sum_serializer_4lane #(
  parameter int DIV_NUM = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Sum,
  input  logic        Cout,
  input  logic        ack,
  output logic        D0,
  output logic        D1,
  output logic        D2,
  output logic        D3,
  output logic        C,
  output logic [2:0]  sel,
  output logic        strobe,
  output logic        busy,
  output logic        finish
);

  localparam logic [3:0] SLOT_LAST = 4'(DIV_NUM - 1);
  localparam logic [3:0] SLOT_HALF = 4'(DIV_NUM / 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        start_d1;
  logic        start_tg;
  logic [31:0] shadow;
  logic [3:0]  slot;
  logic [3:0]  lanes;
  logic        slot_wrap;

  // Bit s of each byte: lane k carries word[8*k + s].
  function automatic logic [3:0] lane_bits(input logic [31:0] word, input logic [2:0] s);
    return {word[{2'd3, s}], word[{2'd2, s}], word[{2'd1, s}], word[{2'd0, s}]};
  endfunction

  assign start_tg  = start & ~start_d1;
  assign slot_wrap = (slot == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_tg) state_next = SHIFT;
      SHIFT:   if (slot_wrap && sel == 3'd7) state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lanes are registered and only move at slot boundaries; the next bit is
  // fetched from the shadow copy so the live Sum input never leaks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d1 <= 1'b0;
      shadow   <= '0;
      slot     <= '0;
      sel      <= '0;
      lanes    <= '0;
      C        <= 1'b0;
    end else begin
      start_d1 <= start;
      case (state)
        IDLE: begin
          if (start_tg) begin
            shadow <= Sum;
            C      <= Cout;
            slot   <= '0;
            sel    <= '0;
            lanes  <= lane_bits(Sum, 3'd0);
          end
        end
        SHIFT: begin
          if (slot_wrap) begin
            slot <= '0;
            if (sel != 3'd7) begin
              sel   <= sel + 3'd1;
              lanes <= lane_bits(shadow, sel + 3'd1);
            end
          end else begin
            slot <= slot + 4'd1;
          end
        end
        DONE: begin
          if (ack) begin
            sel   <= '0;
            lanes <= '0;
          end
        end
        default: begin
          sel   <= '0;
          lanes <= '0;
        end
      endcase
    end
  end

  assign {D3, D2, D1, D0} = lanes;
  assign strobe = (state == SHIFT) && (slot == SLOT_HALF);
  assign busy   = (state == SHIFT);
  assign finish = (state == DONE);

endmodule

// File: tb/tb_sum_serializer_4lane.sv
// Randomized self-checking bench: a DIV_NUM=6 and a DIV_NUM=2 instance are checked
// against a byte-level model of what the strobes must reconstruct.
module tb_sum_serializer_4lane;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] sum_in = '0;
  logic        cout_in = 1'b0;
  logic        ack = 1'b0;

  logic       d0_a, d1_a, d2_a, d3_a, c_a, strobe_a, busy_a, finish_a;
  logic [2:0] sel_a;
  logic       d0_b, d1_b, d2_b, d3_b, c_b, strobe_b, busy_b, finish_b;
  logic [2:0] sel_b;

  int checks = 0;
  int errors = 0;
  bit use_b  = 1'b0;

  always #5 clk = ~clk;

  sum_serializer_4lane #(.DIV_NUM(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .Sum(sum_in), .Cout(cout_in), .ack(ack),
    .D0(d0_a), .D1(d1_a), .D2(d2_a), .D3(d3_a), .C(c_a), .sel(sel_a),
    .strobe(strobe_a), .busy(busy_a), .finish(finish_a)
  );

  sum_serializer_4lane #(.DIV_NUM(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .Sum(sum_in), .Cout(cout_in), .ack(ack),
    .D0(d0_b), .D1(d1_b), .D2(d2_b), .D3(d3_b), .C(c_b), .sel(sel_b),
    .strobe(strobe_b), .busy(busy_b), .finish(finish_b)
  );

  logic [3:0] lanes_v;
  logic [2:0] sel_v;
  logic       c_v, strobe_v, busy_v, finish_v;

  always_comb begin
    lanes_v  = use_b ? {d3_b, d2_b, d1_b, d0_b} : {d3_a, d2_a, d1_a, d0_a};
    sel_v    = use_b ? sel_b : sel_a;
    c_v      = use_b ? c_b : c_a;
    strobe_v = use_b ? strobe_b : strobe_a;
    busy_v   = use_b ? busy_b : busy_a;
    finish_v = use_b ? finish_b : finish_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (use_b) start_b = v;
    else       start_a = v;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_c);
    checks++;
    if ({busy_v, finish_v, strobe_v, sel_v, lanes_v, c_v} !== {1'b0, 1'b0, 1'b0, 3'd0, 4'd0, exp_c}) begin
      errors++;
      $display("[TB] FAIL %s: busy=%b finish=%b strobe=%b sel=%0d lanes=%b C=%b, required all 0 with C=%b",
               tag, busy_v, finish_v, strobe_v, sel_v, lanes_v, c_v, exp_c);
    end
  endtask

  // Runs one transfer and compares against the model: each lane byte equals the
  // matching byte of the word, strobes fall mid-slot, busy lasts 8 slots.
  // disturb >= 0 changes Sum and re-pulses start at that busy cycle.
  task automatic do_transfer(input logic [31:0] word, input logic cy, input int div,
                             input int disturb, input bit do_ack, input string tag);
    logic [7:0] got [4];
    int idx;
    int nstr;
    int overlap;
    set_start(1'b0);
    tick();
    sum_in  = word;
    cout_in = cy;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    idx = 0;
    nstr = 0;
    overlap = 0;
    for (int l = 0; l < 4; l++) got[l] = '0;
    while (busy_v && idx < 400) begin
      if (busy_v && finish_v) overlap++;
      if (strobe_v) begin
        checks++;
        if (idx != nstr * div + div / 2 || sel_v !== 3'(nstr)) begin
          errors++;
          $display("[TB] FAIL %s strobe %0d: cycle=%0d sel=%0d, required cycle=%0d sel=%0d",
                   tag, nstr, idx, sel_v, nstr * div + div / 2, nstr);
        end
        if (nstr < 8)
          for (int l = 0; l < 4; l++) got[l][nstr] = lanes_v[l];
        nstr++;
      end
      if (idx == disturb) begin
        sum_in = 32'hFFFF_FFFF;
        cout_in = ~cy;
      end
      if (disturb >= 0 && idx == disturb + 2) set_start(1'b1);
      if (disturb >= 0 && idx == disturb + 4) set_start(1'b0);
      tick();
      idx++;
    end
    checks++;
    if (idx != 8 * div || nstr != 8 || overlap != 0) begin
      errors++;
      $display("[TB] FAIL %s timing: busy=%0d strobes=%0d overlap=%0d, required busy=%0d strobes=8 overlap=0",
               tag, idx, nstr, overlap, 8 * div);
    end
    checks++;
    if ({got[3], got[2], got[1], got[0]} !== word || c_v !== cy) begin
      errors++;
      $display("[TB] FAIL %s data: lanes=%h C=%b, required %h C=%b",
               tag, {got[3], got[2], got[1], got[0]}, c_v, word, cy);
    end
    checks++;
    if (finish_v !== 1'b1 || busy_v !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done: finish=%b busy=%b, required finish=1 busy=0", tag, finish_v, busy_v);
    end
    if (do_ack) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_idle_outputs({tag, " after ack"}, cy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    use_b = 1'b0;
    check_idle_outputs("reset dut6", 1'b0);
    use_b = 1'b1;
    check_idle_outputs("reset dut2", 1'b0);
    use_b = 1'b0;
  endtask

  task automatic test_basic();
    use_b = 1'b0;
    do_transfer(32'h8421_F00F, 1'b1, 6, -1, 1'b1, "basic");
  endtask

  task automatic test_div2();
    use_b = 1'b1;
    do_transfer(32'h8421_F00F, 1'b1, 2, -1, 1'b1, "div2 fixed");
    for (int i = 0; i < 4; i++)
      do_transfer($urandom, 1'($urandom), 2, -1, 1'b1, "div2 random");
    use_b = 1'b0;
  endtask

  task automatic test_no_restart();
    use_b = 1'b0;
    do_transfer(32'h8421_F00F, 1'b1, 6, 10, 1'b1, "no restart");
  endtask

  task automatic test_hold_ack();
    logic [31:0] word;
    logic [3:0]  last;
    int bad;
    use_b = 1'b0;
    word = $urandom;
    last = {word[31], word[23], word[15], word[7]};
    do_transfer(word, 1'b1, 6, -1, 1'b0, "hold");
    set_start(1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (finish_v !== 1'b1 || busy_v !== 1'b0 || sel_v !== 3'd7 || lanes_v !== last || c_v !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL hold frozen: %0d bad cycles, required 0", bad);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_idle_outputs("hold release", 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_v !== 1'b0 || finish_v !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL held start retrigger: %0d busy cycles, required 0", bad);
    end
    set_start(1'b0);
  endtask

  task automatic test_reset_abort();
    int n;
    int bad;
    use_b = 1'b0;
    set_start(1'b0);
    tick();
    sum_in = $urandom;
    cout_in = 1'b1;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    n = 0;
    while (sel_v !== 3'd4 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sel_v !== 3'd4) begin
      errors++;
      $display("[TB] FAIL abort reach sel4: sel=%0d, required 4", sel_v);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("abort reset", 1'b0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (finish_v !== 1'b0 || busy_v !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL abort no finish: %0d active cycles, required 0", bad);
    end
    do_transfer($urandom, 1'b0, 6, -1, 1'b1, "after abort");
  endtask

  task automatic test_back_to_back();
    use_b = 1'b0;
    do_transfer(32'h0000_0000, 1'b0, 6, -1, 1'b1, "b2b zeros");
    do_transfer(32'hFFFF_FFFF, 1'b1, 6, -1, 1'b1, "b2b ones");
    for (int i = 0; i < 4; i++)
      do_transfer($urandom, 1'($urandom), 6, -1, 1'b1, "b2b random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div2();
    test_no_restart();
    test_hold_ack();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_serializer_4lane.md
SUM_SERIALIZER_4LANE -- requirements
Module: sum_serializer_4lane

Interface
REQ-001 SHALL provide parameter DIV_NUM, default 6, meaning clock cycles per bit slot; legal range 2..15.
REQ-002 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL provide port start  input  1  transfer request, level; rising edge starts a transfer.
REQ-005 SHALL provide port Sum  input  32  result word to transmit; sampled only at transfer start.
REQ-006 SHALL provide port Cout  input  1  carry to transmit; sampled with Sum.
REQ-007 SHALL provide port ack  input  1  downstream consumer has taken the word; releases finish.
REQ-008 SHALL provide port D0, D1, D2, D3  output  1 each  serial lanes carrying bytes 0..3 of Sum.
REQ-009 SHALL provide port C  output  1  captured Cout, held static for the whole transfer.
REQ-010 SHALL provide port sel  output  3  index of the bit currently driven on D0..D3.
REQ-011 SHALL provide port strobe  output  1  one-cycle sample pulse per bit slot.
REQ-012 SHALL provide port busy  output  1  transfer in progress.
REQ-013 SHALL provide port finish  output  1  transfer complete, awaiting ack.

Function
REQ-014 SHALL detect start edge as start_tg = start & ~start_d1, start_d1 a one-cycle registered copy of start.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; encoding free.
REQ-016 IDLE: on start_tg, SHALL capture Sum/Cout into shadow registers, clear sel and slot counter, set busy, enter SHIFT on the next edge.
REQ-017 SHIFT: SHALL drive D0=shadow[sel], D1=shadow[8+sel], D2=shadow[16+sel], D3=shadow[24+sel], all registered, changing only at slot boundaries.
REQ-018 Slot counter SHALL count 0..DIV_NUM-1; on reaching DIV_NUM-1 it wraps to 0 and sel increments.
REQ-019 strobe SHALL be 1 for exactly the cycle where slot counter == DIV_NUM/2 (integer division), 0 otherwise, in SHIFT only.
REQ-020 On slot wrap with sel==7, SHALL enter DONE; sel SHALL NOT wrap to 0 in SHIFT; SHIFT lasts exactly 8*DIV_NUM cycles.
REQ-021 DONE: busy=0, finish=1; D0..D3, C, sel hold last values; finish SHALL stay 1 until ack==1, then return to IDLE next edge with finish=0.
REQ-022 ack SHALL be ignored in IDLE and SHIFT; ack already high on DONE entry SHALL release after one DONE cycle.
REQ-023 start_tg in SHIFT or DONE SHALL be ignored; shadow registers SHALL NOT change mid-transfer even if Sum changes.
REQ-024 start held high through DONE->IDLE SHALL NOT retrigger; a fresh 0->1 edge is required.
REQ-025 busy and finish SHALL never be 1 simultaneously; exactly 8 strobes SHALL occur per transfer.
REQ-026 In IDLE, D0..D3, sel, strobe SHALL be 0; C holds the last captured value.

Reset
REQ-027 With rst==1 at a clock edge, SHALL go to IDLE and clear D0..D3, C, sel, strobe, busy, finish, start_d1, counters, shadow registers.
REQ-028 rst asserted in SHIFT or DONE SHALL abort the transfer; no finish is produced for the aborted word.
REQ-029 rst SHALL take priority over start, ack and all counter updates in the same cycle.

Verification
REQ-030 DIV_NUM=6, Sum=32'h8421_F00F, Cout=1, start pulse -> busy 1 for 48 cycles; strobe samples sel 0..7 rebuild D0 byte 0x0F, D1 0xF0, D2 0x21, D3 0x84; C=1; then finish=1.
REQ-031 Strobe timing: DIV_NUM=6 -> strobe at slot count 3, 6 cycles apart, 8 pulses total; DIV_NUM=2 -> strobe every 2 cycles, SHIFT = 16 cycles.
REQ-032 Sum changed to 32'hFFFF_FFFF and start re-pulsed mid-SHIFT -> lanes still carry 32'h8421_F00F; no restart; busy length unchanged.
REQ-033 finish held 20 cycles with ack=0 -> finish stays 1, outputs frozen; ack=1 for one cycle -> finish=0, IDLE next edge; start held high meanwhile -> no new transfer.
REQ-034 rst=1 at sel==4 -> next edge all outputs 0, IDLE; next start edge -> full 8-slot transfer of the newly sampled Sum.
REQ-035 Sum=32'h0000_0000, Cout=0 back-to-back with Sum=32'hFFFF_FFFF, Cout=1 (ack at finish) -> lanes all 0 then all 1 with C following; no stale bits.
